// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB GPIO with direction, set/clear, input sync and edge interrupts
module apb_gpio_irq #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       bus_if_paddr,
  input  logic             bus_if_psel,
  input  logic             bus_if_penable,
  input  logic             bus_if_pwrite,
  input  logic [WIDTH-1:0] bus_if_pwdata,
  output logic [WIDTH-1:0] bus_if_prdata,
  output logic             bus_if_pready,
  output logic [WIDTH-1:0] output_port,
  output logic [WIDTH-1:0] output_enable,
  output logic             output_update,
  input  logic [WIDTH-1:0] input_port,
  output logic             input_sampled,
  output logic             irq
);
  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;
  logic state;
  logic we;
  logic [WIDTH-1:0] sync_in, prev, pend, rise_en, fall_en, rd, clr;
  if (SYNC_STAGES == 0) begin : g_direct
    assign sync_in = input_port;
  end else begin : g_sync
    logic [WIDTH-1:0] chain [SYNC_STAGES];
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
        always_ff @(posedge clk) chain[s] <= rst ? '0 : input_port;
      end else begin : g_next
        always_ff @(posedge clk) chain[s] <= rst ? '0 : chain[s-1];
      end
    end
    assign sync_in = chain[SYNC_STAGES-1];
  end
  assign bus_if_pready = state == WAIT;
  assign we = state == WAIT && bus_if_psel && bus_if_pwrite;
  assign input_sampled = state == WAIT && bus_if_psel && !bus_if_pwrite && bus_if_paddr == 3'd0;
  assign irq = |pend;
  assign clr = we && bus_if_paddr == 3'd6 ? bus_if_pwdata : '0;
  always_comb
    rd = bus_if_paddr == 3'd0 ? sync_in :
         bus_if_paddr == 3'd1 || bus_if_paddr == 3'd2 ? output_port :
         bus_if_paddr == 3'd3 ? output_enable :
         bus_if_paddr == 3'd4 ? rise_en :
         bus_if_paddr == 3'd5 ? fall_en :
         bus_if_paddr == 3'd6 ? pend : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus_if_prdata <= '0;
      output_port   <= '0;
      output_enable <= '0;
      output_update <= 1'b0;
      rise_en       <= '0;
      fall_en       <= '0;
      prev          <= '0;
      pend          <= '0;
    end else begin
      state <= state == IDLE && bus_if_psel && bus_if_penable ? WAIT : IDLE;
      if (state == IDLE && bus_if_psel && bus_if_penable && !bus_if_pwrite) bus_if_prdata <= rd;
      output_update <= we && bus_if_paddr < 3'd3;
      if (we)
        case (bus_if_paddr)
          3'd0: output_port <= bus_if_pwdata;
          3'd1: output_port <= output_port | bus_if_pwdata;
          3'd2: output_port <= output_port & ~bus_if_pwdata;
          3'd3: output_enable <= bus_if_pwdata;
          3'd4: rise_en <= bus_if_pwdata;
          3'd5: fall_en <= bus_if_pwdata;
          default: ;
        endcase
      prev <= sync_in;
      pend <= (pend & ~clr) | (sync_in & ~prev & rise_en) | (~sync_in & prev & fall_en);
    end
  end
endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb_apb_gpio_irq: directed table-driven checks of apb_gpio_irq plus interrupt and reset sequences
module tb_apb_gpio_irq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] paddr;
  logic psel, penable, pwrite;
  logic [W-1:0] pwdata, prdata, out, oe, inp;
  logic pready, upd, samp, irq;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [2:0]   a;
    logic         wr;
    logic [W-1:0] d;
    logic [W-1:0] er;
    logic [W-1:0] eo;
    logic [W-1:0] ee;
    logic         eu;
  } vec_t;
  vec_t v[$];
  apb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .bus_if_paddr(paddr), .bus_if_psel(psel), .bus_if_penable(penable),
    .bus_if_pwrite(pwrite), .bus_if_pwdata(pwdata), .bus_if_prdata(prdata),
    .bus_if_pready(pready), .output_port(out), .output_enable(oe),
    .output_update(upd), .input_port(inp), .input_sampled(samp), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic xfer(input logic [2:0] a, input logic wr, input logic [W-1:0] d,
                      output logic [W-1:0] rd, output logic s, output logic u);
    paddr = a; pwrite = wr; pwdata = d; psel = 1'b1; penable = 1'b0;
    chk("pready_setup", pready, 0);
    @(negedge clk);
    penable = 1'b1;
    chk("pready_access", pready, 0);
    @(negedge clk);
    chk("pready_wait", pready, 1);
    rd = prdata;
    s = samp;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    u = upd;
  endtask
  initial begin
    logic [W-1:0] rd;
    logic s, u;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; inp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_out", out, 0);
    chk("rst_oe", oe, 0);
    chk("rst_upd", upd, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 8; i++) v.push_back('{i[2:0], 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
    v.push_back('{3'd0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1});
    v.push_back('{3'd1, 1'b1, 8'h0F, 8'h00, 8'hAF, 8'h00, 1'b1});
    v.push_back('{3'd2, 1'b1, 8'h81, 8'h00, 8'h2E, 8'h00, 1'b1});
    v.push_back('{3'd1, 1'b0, 8'h00, 8'h2E, 8'h2E, 8'h00, 1'b0});
    v.push_back('{3'd2, 1'b0, 8'h00, 8'h2E, 8'h2E, 8'h00, 1'b0});
    v.push_back('{3'd3, 1'b1, 8'h3C, 8'h00, 8'h2E, 8'h3C, 1'b0});
    v.push_back('{3'd3, 1'b0, 8'h00, 8'h3C, 8'h2E, 8'h3C, 1'b0});
    v.push_back('{3'd7, 1'b1, 8'hFF, 8'h00, 8'h2E, 8'h3C, 1'b0});
    v.push_back('{3'd7, 1'b0, 8'h00, 8'h00, 8'h2E, 8'h3C, 1'b0});
    v.push_back('{3'd0, 1'b1, 8'h2E, 8'h00, 8'h2E, 8'h3C, 1'b1});
    v.push_back('{3'd6, 1'b0, 8'h00, 8'h00, 8'h2E, 8'h3C, 1'b0});
    foreach (v[i]) begin
      xfer(v[i].a, v[i].wr, v[i].d, rd, s, u);
      if (!v[i].wr) chk($sformatf("v%0d_rdata", i), rd, v[i].er);
      chk($sformatf("v%0d_sampled", i), s, !v[i].wr && v[i].a == 3'd0);
      chk($sformatf("v%0d_out", i), out, v[i].eo);
      chk($sformatf("v%0d_oe", i), oe, v[i].ee);
      chk($sformatf("v%0d_update", i), u, v[i].eu);
      chk($sformatf("v%0d_irq", i), irq, 0);
    end
    @(negedge clk);
    chk("upd_single_pulse", upd, 0);
    xfer(3'd4, 1'b1, 8'h01, rd, s, u);
    inp[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rise_irq_early", irq, 0);
    @(negedge clk);
    chk("rise_irq", irq, 1);
    xfer(3'd6, 1'b0, 8'h00, rd, s, u);
    chk("rise_pend", rd, 8'h01);
    xfer(3'd0, 1'b0, 8'h00, rd, s, u);
    chk("data_read", rd, 8'h01);
    chk("data_sampled", s, 1);
    xfer(3'd6, 1'b1, 8'h01, rd, s, u);
    chk("w1c_irq", irq, 0);
    xfer(3'd5, 1'b1, 8'h80, rd, s, u);
    inp[7] = 1'b1;
    repeat (4) @(negedge clk);
    chk("rise7_not_enabled", irq, 0);
    inp[7] = 1'b0;
    xfer(3'd6, 1'b1, 8'h80, rd, s, u);
    chk("set_wins_irq", irq, 1);
    xfer(3'd6, 1'b0, 8'h00, rd, s, u);
    chk("set_wins_pend", rd, 8'h80);
    xfer(3'd6, 1'b1, 8'h80, rd, s, u);
    chk("clear_irq", irq, 0);
    xfer(3'd6, 1'b0, 8'h00, rd, s, u);
    chk("clear_pend", rd, 8'h00);
    paddr = 3'd0; pwrite = 1'b1; pwdata = 8'hFF; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("abort_pready_wait", pready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    chk("abort_out", out, 0);
    chk("abort_upd", upd, 0);
    chk("abort_pready", pready, 0);
    chk("abort_oe", oe, 0);
    @(negedge clk);
    chk("abort_out_next", out, 0);
    chk("abort_upd_next", upd, 0);
    chk("abort_idle", pready, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
